fb_write_sched: RTL and testbench

//  Owns the write port of the frame-buffer dual_port_ram. The RAM has no write

---
 rtl/fb_write_sched_pkg.sv | 17 +
 rtl/fb_write_sched.sv | 102 ++++++++++
 tb/tb_fb_write_sched.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/fb_write_sched_pkg.sv
// Shared frame-buffer constants and write-scheduler FSM encodings.
package fb_write_sched_pkg;

  localparam int FB_WIDTH  = 13;
  localparam int FB_LENGTH = 12;
  localparam logic [FB_WIDTH-1:0] FB_PARK_ADDR = '1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_SLOT  = 2'd2;

  // Renderer may only be granted outside clear-word cycles.
  function automatic logic px_grant(input logic [1:0] st);
    return (st == ST_IDLE) || (st == ST_SLOT);
  endfunction

endpackage

// File: rtl/fb_write_sched.sv
// Frame-buffer write-port owner: arbitrates clear sweep vs renderer pixels and
// parks the always-writing RAM port on a reserved word when idle.
module fb_write_sched
  import fb_write_sched_pkg::*;
#(
  parameter int                WIDTH       = FB_WIDTH,
  parameter int                LENGTH      = FB_LENGTH,
  parameter logic [WIDTH-1:0]  PARK_ADDR   = {WIDTH{1'b1}},
  parameter logic [LENGTH-1:0] PARK_DATA   = '0,
  parameter logic [LENGTH-1:0] CLEAR_VALUE = '0,
  parameter int                CLEAR_BURST = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic              clear_done,
  input  logic              px_valid,
  output logic              px_ready,
  input  logic [WIDTH-1:0]  px_addr,
  input  logic [LENGTH-1:0] px_data,
  output logic [WIDTH-1:0]  ram_write_addr,
  output logic [LENGTH-1:0] ram_din
);

  localparam logic [WIDTH-1:0] CLEAR_LAST = PARK_ADDR - WIDTH'(1);
  localparam logic [WIDTH-1:0] BURST_LAST = WIDTH'(CLEAR_BURST - 1);

  logic [1:0]        state_q, state_d;
  logic [WIDTH-1:0]  clear_addr_q, clear_addr_d;
  logic [WIDTH-1:0]  burst_cnt_q, burst_cnt_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  waddr_q, waddr_d;
  logic [LENGTH-1:0] wdin_q, wdin_d;
  logic              px_fire;

  // Decoded from the state register only, so px_valid never reaches px_ready.
  assign px_ready = px_grant(state_q);
  assign px_fire  = px_valid && px_ready;

  always_comb begin
    state_d      = state_q;
    clear_addr_d = clear_addr_q;
    burst_cnt_d  = burst_cnt_q;
    done_d       = 1'b0;
    waddr_d      = PARK_ADDR;
    wdin_d       = PARK_DATA;
    if (px_fire) begin
      waddr_d = px_addr;
      wdin_d  = px_data;
    end
    case (state_q)
      ST_IDLE: begin
        if (clear_start) begin
          state_d      = ST_CLEAR;
          clear_addr_d = '0;
          burst_cnt_d  = '0;
        end
      end
      ST_CLEAR: begin
        waddr_d      = clear_addr_q;
        wdin_d       = CLEAR_VALUE;
        clear_addr_d = clear_addr_q + WIDTH'(1);
        burst_cnt_d  = burst_cnt_q + WIDTH'(1);
        // Terminal word wins over the burst boundary: no trailing slot.
        if (clear_addr_q == CLEAR_LAST) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (burst_cnt_q == BURST_LAST) begin
          state_d     = ST_SLOT;
          burst_cnt_d = '0;
        end
      end
      ST_SLOT: state_d = ST_CLEAR;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      clear_addr_q <= '0;
      burst_cnt_q  <= '0;
      done_q       <= 1'b0;
      waddr_q      <= PARK_ADDR;
      wdin_q       <= PARK_DATA;
    end else begin
      state_q      <= state_d;
      clear_addr_q <= clear_addr_d;
      burst_cnt_q  <= burst_cnt_d;
      done_q       <= done_d;
      waddr_q      <= waddr_d;
      wdin_q       <= wdin_d;
    end
  end

  assign clear_busy     = (state_q != ST_IDLE);
  assign clear_done     = done_q;
  assign ram_write_addr = waddr_q;
  assign ram_din        = wdin_q;

endmodule

// File: tb/tb_fb_write_sched.sv
// Scoreboard bench for fb_write_sched with a small behavioural write-every-cycle RAM.
module tb_fb_write_sched;

  logic       clk;
  logic       rst;
  logic       clear_start;
  logic       clear_busy;
  logic       clear_done;
  logic       px_valid;
  logic       px_ready;
  logic [3:0] px_addr;
  logic [7:0] px_data;
  logic [3:0] ram_write_addr;
  logic [7:0] ram_din;

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] mem[16];
  int         n_checks;
  int         n_fail;

  fb_write_sched #(
    .WIDTH(4), .LENGTH(8), .PARK_ADDR(4'd15), .PARK_DATA(8'h00),
    .CLEAR_VALUE(8'h00), .CLEAR_BURST(4)
  ) dut (
    .clk(clk), .rst(rst), .clear_start(clear_start), .clear_busy(clear_busy),
    .clear_done(clear_done), .px_valid(px_valid), .px_ready(px_ready),
    .px_addr(px_addr), .px_data(px_data), .ram_write_addr(ram_write_addr),
    .ram_din(ram_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM with no write enable: commits the registered pair every edge.
  always @(posedge clk) mem[ram_write_addr] <= ram_din;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] a, input logic [7:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic push_clear(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) push(4'(a), 8'h00);
  endtask

  task automatic px_write(input logic [3:0] a, input logic [7:0] d);
    push(a, d);
    px_valid = 1'b1;
    px_addr  = a;
    px_data  = d;
    chk("px_ready_idle", {31'd0, px_ready}, 32'd1);
    tick();
    px_valid = 1'b0;
  endtask

  task automatic fill_ff();
    for (int a = 0; a < 15; a++) px_write(4'(a), 8'hFF);
    tick();
    tick();
  endtask

  // Caller raises clear_start (and optionally a colliding pixel) before calling.
  task automatic run_sweep(input int retrig_at, input bit offer_px,
                           output int busy_n, output int done_n, output int rdy_n);
    logic xfer;
    busy_n = 0;
    done_n = 0;
    rdy_n  = 0;
    for (int i = 0; i < 30; i++) begin
      xfer = px_valid && px_ready;
      if (i == retrig_at) clear_start = 1'b1;
      tick();
      clear_start = 1'b0;
      if (xfer) px_valid = 1'b0;
      if (i == 0 && offer_px) begin
        px_valid = 1'b1;
        px_addr  = 4'd9;
        px_data  = 8'h5C;
      end
      if (clear_busy) busy_n++;
      if (clear_busy && px_ready) rdy_n++;
      if (clear_done) done_n++;
    end
  endtask

  initial begin
    int busy_n, done_n, rdy_n;
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b1;
    clear_start = 1'b0;
    px_valid    = 1'b0;
    px_addr     = '0;
    px_data     = '0;

    // 1: asynchronous reset takes effect before any clock edge
    #2 rst = 1'b0;
    #1;
    chk("rst_addr",  {28'd0, ram_write_addr}, 32'd15);
    chk("rst_din",   {24'd0, ram_din}, 32'h00);
    chk("rst_ready", {31'd0, px_ready}, 32'd1);
    chk("rst_busy",  {31'd0, clear_busy}, 32'd0);
    chk("rst_done",  {31'd0, clear_done}, 32'd0);

    fork
      forever begin
        @(negedge clk);
        if (rst && ram_write_addr != 4'd15) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected none at %0t",
                     ram_write_addr, ram_din, $time);
          end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_addr", {28'd0, ram_write_addr}, {28'd0, e.a});
            chk("wr_data", {24'd0, ram_din}, {24'd0, e.d});
          end
        end
      end
    join_none

    tick();
    tick();
    rst = 1'b1;
    tick();

    // 2: idle stream, one pixel per cycle
    px_write(4'd3, 8'hA1);
    px_write(4'd5, 8'hA2);
    px_write(4'd7, 8'hA3);
    tick();
    tick();
    chk("ram3", {24'd0, mem[3]}, 32'hA1);
    chk("ram5", {24'd0, mem[5]}, 32'hA2);
    chk("ram7", {24'd0, mem[7]}, 32'hA3);

    // 3: full sweep over an all-FF buffer
    fill_ff();
    push_clear(0, 14);
    clear_start = 1'b1;
    run_sweep(-1, 1'b0, busy_n, done_n, rdy_n);
    chk("s3_busy_cycles", busy_n, 18);
    chk("s3_done_pulses", done_n, 1);
    chk("s3_slot_ready",  rdy_n, 3);
    for (int a = 0; a < 15; a++) chk("s3_cleared", {24'd0, mem[a]}, 32'h00);
    chk("s3_park_word", {24'd0, mem[15]}, 32'h00);

    // 4: pixel held during sweep lands in the first slot, then gets cleared
    fill_ff();
    push_clear(0, 3);
    push(4'd9, 8'h5C);
    push_clear(4, 14);
    clear_start = 1'b1;
    run_sweep(-1, 1'b1, busy_n, done_n, rdy_n);
    chk("s4_busy_cycles", busy_n, 18);
    chk("s4_done_pulses", done_n, 1);
    chk("s4_slot_ready",  rdy_n, 3);
    chk("s4_px_taken",    {31'd0, px_valid}, 32'd0);
    chk("s4_ram9",        {24'd0, mem[9]}, 32'h00);

    // 5a: retrigger mid-sweep is ignored
    push_clear(0, 14);
    clear_start = 1'b1;
    run_sweep(5, 1'b0, busy_n, done_n, rdy_n);
    chk("s5_retrig_busy", busy_n, 18);
    chk("s5_retrig_done", done_n, 1);

    // 5b: pixel offered together with clear_start goes out first
    push(4'd6, 8'h77);
    push_clear(0, 14);
    px_valid    = 1'b1;
    px_addr     = 4'd6;
    px_data     = 8'h77;
    clear_start = 1'b1;
    run_sweep(-1, 1'b0, busy_n, done_n, rdy_n);
    chk("s5_coll_busy", busy_n, 18);
    chk("s5_coll_done", done_n, 1);
    chk("s5_coll_ram6", {24'd0, mem[6]}, 32'h00);

    // 6: reset after six clear words have been committed
    fill_ff();
    push_clear(0, 5);
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    repeat (8) tick();
    rst = 1'b0;
    #1;
    chk("s6_busy",  {31'd0, clear_busy}, 32'd0);
    chk("s6_addr",  {28'd0, ram_write_addr}, 32'd15);
    chk("s6_din",   {24'd0, ram_din}, 32'h00);
    chk("s6_ready", {31'd0, px_ready}, 32'd1);
    done_n = 0;
    repeat (2) begin
      tick();
      if (clear_done) done_n++;
    end
    rst = 1'b1;
    repeat (4) begin
      tick();
      if (clear_done) done_n++;
    end
    chk("s6_no_done", done_n, 0);
    chk("s6_idle",    {31'd0, clear_busy}, 32'd0);
    for (int a = 0; a < 6; a++)  chk("s6_cleared", {24'd0, mem[a]}, 32'h00);
    for (int a = 6; a < 15; a++) chk("s6_kept",    {24'd0, mem[a]}, 32'hFF);

    tick();
    chk("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
